bmc_subframe_decoder: RTL and testbench
=======================================

Name: bmc_subframe_decoder

Overview:
- Parametrised biphase-mark (S/PDIF) receiver front end that replaces the fixed 5-tap window decoder.
- Measures edge-to-edge intervals against a runtime unit-interval (UI) length and classifies each one.
- Decodes B/M/W preambles and the 28 data slots, tracks slot position and reports lock and error status.
- Feeds the subframe deserialiser downstream.

Parameters:
CNT_W, 8, width of interval counter and i_ui; counter saturates at 2^CNT_W-1
LOCK_PRE, 2, consecutive error-free subframes required before o_locked rises (1..15)

Ports:
clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset; clears all state
ena  input  1  sample enable; i_spdif is sampled and the interval counter advances only when high
i_spdif  input  1  raw BMC line, asynchronous to clk
i_ui  input  CNT_W  UI length in ena samples (half a bit cell); read on every classification
o_decoded_data  output  1  decoded bit, valid while o_data_valid=1
o_data_valid  output  1  one-clk strobe per decoded data bit
o_slot  output  5  slot index of the current o_decoded_data (4..31)
o_preamble  output  2  0=B, 1=M, 2=W; valid while o_pre_valid=1
o_pre_valid  output  1  one-clk strobe per recognised preamble
o_locked  output  1  stream trusted
o_err  output  1  one-clk strobe on any protocol/timing error

Behaviour:
- Reset: all outputs 0, FSM=HUNT, lock count 0, counter 0, sync flops 0.
- Input path: 2-flop synchroniser plus one history flop, all clocked on ena. Edge = XOR of the last two stages.
- Interval counter:
  - Increments per ena cycle and saturates.
  - On an edge, L = count+1 and the counter reloads to 0.
  - ena low freezes the counter and the sample path.
- Classification (integer compares, u = i_ui):
  - 2L<u → GLITCH
  - 2L<3u → S
  - 2L<5u → G
  - 2L<7u → X
  - else → ERR
- Timeout: if 2*count >= 7u with no edge, fire ERR once; no further err until the next edge.
- u=0: FSM held in HUNT; no strobes.
- FSM states:
  - HUNT: X→PRE1; all else ignored (no err).
  - PRE1/PRE2/PRE3: collect the next 3 classes.
    - S,S,X → B; X,S,S → M; G,S,G → W.
    - Match: o_pre_valid pulse, o_preamble set, o_slot←4, →DATA.
    - Mismatch: ERR.
  - DATA: G → bit 0. S with pending=0 → pending=1. S with pending=1 → bit 1, pending=0.
    - After each bit: o_data_valid pulse, o_slot increments.
    - After slot 31 → EXPX.
    - X, G-while-pending, GLITCH → ERR.
  - EXPX: X → PRE1, and the subframe counts as good. Else ERR.
- ERR action (any state):
  - o_err pulse; o_locked←0; lock count←0; pending←0; →HUNT.
  - The offending interval is discarded. An X that caused the error does not re-enter PRE1.
- Lock:
  - Good-subframe counter increments on each EXPX→PRE1 and saturates at LOCK_PRE.
  - o_locked rises in the same clk as that count reaches LOCK_PRE.
  - Strobes are emitted regardless of lock.
- Latency: ena=1 continuously; o_data_valid/o_pre_valid assert exactly 3 clk after the first clk edge that samples the new i_spdif level at the bit's closing transition. Latency is constant for all bits and preambles.
- i_ui changes take effect at the next classification or timeout check; no reset required.
- o_decoded_data and o_slot hold their values between strobes.
- Async reset mid-subframe: immediate clear; decoding restarts from HUNT.

Test Plan:
- u=4, ena=1, B preamble + 28 slots alternating 1,0 + M preamble → o_pre_valid with 0, then 28 o_data_valid with data 1,0,… and o_slot 4..31, then o_pre_valid with 1; latency 3 clk each.
- W preamble (intervals 12,8,4,8 samples) followed by all-zero slots → o_preamble=2; 28 bits of 0 spaced 8 clk apart.
- Lock: 3 clean subframes, LOCK_PRE=2 → o_locked=1 after the 2nd EXPX→PRE1; then inject an S followed by a G in DATA → o_err pulse, o_locked=0, no more strobes until the next X.
- Timeout: u=4, line held static → o_err exactly once at count 14 (2*14>=28); an edge followed by a clean stream relocks.
- Glitch: 1-sample pulse mid-DATA → GLITCH → o_err, HUNT.
- Mode: switch i_ui 4→2 between subframes with ena=1 → decoding continues; bits now 4 clk apart; no err; lock retained.

Source files
------------

// File: rtl/bmc_subframe_decoder.sv
`timescale 1ns/1ps
// bmc_subframe_decoder: biphase-mark (S/PDIF) receiver front end.
// The line is synchronised, and each edge-to-edge interval is measured and
// classified against a runtime unit interval (i_ui). A three-process FSM then
// recognises B/M/W preambles, decodes the 28 data slots, and tracks lock.
// Pipeline: sync1 -> sync2/hist (edge) -> interval event -> registered outputs.
module bmc_subframe_decoder #(
  parameter int CNT_W    = 8,
  parameter int LOCK_PRE = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             ena,
  input  logic             i_spdif,
  input  logic [CNT_W-1:0] i_ui,
  output logic             o_decoded_data,
  output logic             o_data_valid,
  output logic [4:0]       o_slot,
  output logic [1:0]       o_preamble,
  output logic             o_pre_valid,
  output logic             o_locked,
  output logic             o_err
);

  // Compare width: 7*u fits in CNT_W+3 bits; one spare bit keeps headroom.
  localparam int               CW      = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_PRE);
  localparam logic [1:0]       PRE_B   = 2'd0;
  localparam logic [1:0]       PRE_M   = 2'd1;
  localparam logic [1:0]       PRE_W   = 2'd2;

  typedef enum logic [2:0] {CLS_GLITCH, CLS_S, CLS_G, CLS_X, CLS_ERR} cls_e;
  typedef enum logic [2:0] {ST_HUNT, ST_PRE1, ST_PRE2, ST_PRE3, ST_DATA, ST_EXPX} state_e;

  // Input path and interval measurement
  logic             sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic             line_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   len;
  logic [CW-1:0]    len2, cnt2, u1, u3, u5, u7;
  cls_e             edge_cls;
  logic             tmo_hit, tmo_done_q, tmo_done_d;

  // Interval event stage
  logic             evt_vld_q, evt_vld_d, evt_tmo_q, evt_tmo_d;
  cls_e             evt_cls_q, evt_cls_d;

  // Decoder FSM and its datapath
  state_e           state_q, state_d;
  logic             ui_zero;
  logic             err_ev, pre_ev, bit_ev, bit_val, set_pend, good_ev;
  logic [1:0]       pre_code;
  cls_e             c1_q, c1_d, c2_q, c2_d;
  logic             pend_q, pend_d;
  logic [4:0]       next_slot_q, next_slot_d;
  logic [3:0]       good_q, good_d;
  logic             data_q, data_d, dvalid_q, dvalid_d, pvalid_q, pvalid_d;
  logic             locked_q, locked_d, err_q, err_d;
  logic [4:0]       slot_q, slot_d;
  logic [1:0]       pre_q, pre_d;

  assign line_edge = sync2_q ^ hist_q;
  assign ui_zero   = (i_ui == '0);

  // Sample path: every stage advances only on an enabled sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    hist_d  = hist_q;
    if (ena) begin
      sync1_d = i_spdif;
      sync2_d = sync1_q;
      hist_d  = sync2_q;
    end
  end

  // Interval counter, classification and one-shot timeout detection.
  always_comb begin
    len  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    len2 = CW'(len) << 1;
    cnt2 = CW'(cnt_q) << 1;
    u1   = CW'(i_ui);
    u3   = u1 + (u1 << 1);
    u5   = u1 + (u1 << 2);
    u7   = (u1 << 3) - u1;

    if      (len2 < u1) edge_cls = CLS_GLITCH;
    else if (len2 < u3) edge_cls = CLS_S;
    else if (len2 < u5) edge_cls = CLS_G;
    else if (len2 < u7) edge_cls = CLS_X;
    else                edge_cls = CLS_ERR;

    // A silent line reports once; the flag re-arms only on the next edge.
    tmo_hit = ena && !line_edge && !ui_zero && !tmo_done_q && (cnt2 >= u7);

    cnt_d      = cnt_q;
    tmo_done_d = tmo_done_q;
    if (ena) begin
      if (line_edge) begin
        cnt_d      = '0;
        tmo_done_d = 1'b0;
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit) tmo_done_d = 1'b1;
      end
    end

    evt_vld_d = ena && line_edge;
    evt_tmo_d = tmo_hit;
    evt_cls_d = edge_cls;
  end

  // Front-end and event-stage registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      cnt_q      <= '0;
      tmo_done_q <= 1'b0;
      evt_vld_q  <= 1'b0;
      evt_tmo_q  <= 1'b0;
      evt_cls_q  <= CLS_GLITCH;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      tmo_done_q <= tmo_done_d;
      evt_vld_q  <= evt_vld_d;
      evt_tmo_q  <= evt_tmo_d;
      evt_cls_q  <= evt_cls_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_HUNT;
    else          state_q <= state_d;
  end

  // Next-state logic; also flags which decode action the current event causes.
  always_comb begin
    state_d  = state_q;
    err_ev   = 1'b0;
    pre_ev   = 1'b0;
    pre_code = PRE_B;
    bit_ev   = 1'b0;
    bit_val  = 1'b0;
    set_pend = 1'b0;
    good_ev  = 1'b0;
    if (ui_zero) begin
      state_d = ST_HUNT;
    end else if (evt_tmo_q) begin
      err_ev  = 1'b1;
      state_d = ST_HUNT;
    end else if (evt_vld_q) begin
      case (state_q)
        ST_HUNT: if (evt_cls_q == CLS_X) state_d = ST_PRE1;
        ST_PRE1: state_d = ST_PRE2;
        ST_PRE2: state_d = ST_PRE3;
        ST_PRE3: begin
          if (c1_q == CLS_S && c2_q == CLS_S && evt_cls_q == CLS_X) begin
            pre_ev = 1'b1; pre_code = PRE_B;
          end else if (c1_q == CLS_X && c2_q == CLS_S && evt_cls_q == CLS_S) begin
            pre_ev = 1'b1; pre_code = PRE_M;
          end else if (c1_q == CLS_G && c2_q == CLS_S && evt_cls_q == CLS_G) begin
            pre_ev = 1'b1; pre_code = PRE_W;
          end
          if (pre_ev) state_d = ST_DATA;
          else begin
            err_ev  = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_DATA: begin
          case (evt_cls_q)
            CLS_G: if (pend_q) err_ev = 1'b1;
                   else begin bit_ev = 1'b1; bit_val = 1'b0; end
            CLS_S: if (pend_q) begin bit_ev = 1'b1; bit_val = 1'b1; end
                   else set_pend = 1'b1;
            default: err_ev = 1'b1;
          endcase
          if (err_ev)                              state_d = ST_HUNT;
          else if (bit_ev && next_slot_q == 5'd31) state_d = ST_EXPX;
        end
        ST_EXPX: begin
          if (evt_cls_q == CLS_X) begin
            good_ev = 1'b1;
            state_d = ST_PRE1;
          end else begin
            err_ev  = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Output and datapath updates driven by the decode action.
  always_comb begin
    data_d      = data_q;
    dvalid_d    = 1'b0;
    slot_d      = slot_q;
    pre_d       = pre_q;
    pvalid_d    = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    next_slot_d = next_slot_q;
    pend_d      = pend_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    good_d      = good_q;
    if (evt_vld_q && state_q == ST_PRE1) c1_d = evt_cls_q;
    if (evt_vld_q && state_q == ST_PRE2) c2_d = evt_cls_q;
    if (set_pend) pend_d = 1'b1;
    if (pre_ev) begin
      pvalid_d    = 1'b1;
      pre_d       = pre_code;
      slot_d      = 5'd4;
      next_slot_d = 5'd4;
      pend_d      = 1'b0;
    end
    if (bit_ev) begin
      dvalid_d    = 1'b1;
      data_d      = bit_val;
      slot_d      = next_slot_q;
      next_slot_d = next_slot_q + 5'd1;
      pend_d      = 1'b0;
    end
    if (good_ev) begin
      if (good_q != LOCK_N) good_d = good_q + 4'd1;
      if (good_d == LOCK_N) locked_d = 1'b1;
    end
    if (err_ev) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      good_d   = '0;
      pend_d   = 1'b0;
    end
    if (ui_zero) pend_d = 1'b0;
  end

  // Decoder datapath and output registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q      <= 1'b0;
      dvalid_q    <= 1'b0;
      slot_q      <= '0;
      pre_q       <= '0;
      pvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      next_slot_q <= '0;
      pend_q      <= 1'b0;
      c1_q        <= CLS_GLITCH;
      c2_q        <= CLS_GLITCH;
      good_q      <= '0;
    end else begin
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      slot_q      <= slot_d;
      pre_q       <= pre_d;
      pvalid_q    <= pvalid_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      next_slot_q <= next_slot_d;
      pend_q      <= pend_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      good_q      <= good_d;
    end
  end

  assign o_decoded_data = data_q;
  assign o_data_valid   = dvalid_q;
  assign o_slot         = slot_q;
  assign o_preamble     = pre_q;
  assign o_pre_valid    = pvalid_q;
  assign o_locked       = locked_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_bmc_subframe_decoder.sv
`timescale 1ns/1ps
// tb_bmc_subframe_decoder: drives BMC interval streams, pushes the expected
// strobes (kind, payload, lock, arrival cycle) to a queue, and a negedge
// monitor pops and compares each strobe the decoder produces.
module tb_bmc_subframe_decoder;
  localparam int CNT_W    = 8;
  localparam int LOCK_PRE = 2;
  localparam int K_PRE    = 0;
  localparam int K_BIT    = 1;
  localparam int K_ERR    = 2;

  logic             clk     = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             ena     = 1'b1;
  logic             i_spdif = 1'b0;
  logic [CNT_W-1:0] i_ui    = '0;
  logic             o_decoded_data, o_data_valid, o_pre_valid, o_locked, o_err;
  logic [4:0]       o_slot;
  logic [1:0]       o_preamble;

  bmc_subframe_decoder #(.CNT_W(CNT_W), .LOCK_PRE(LOCK_PRE)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .ena(ena), .i_spdif(i_spdif), .i_ui(i_ui),
    .o_decoded_data(o_decoded_data), .o_data_valid(o_data_valid), .o_slot(o_slot),
    .o_preamble(o_preamble), .o_pre_valid(o_pre_valid), .o_locked(o_locked),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic       data;
    logic [4:0] slot;
    logic [1:0] pre;
    logic       lock;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cur_u    = 0;
  int   m_good   = 0;
  logic m_locked = 1'b0;
  bit   m_expx   = 1'b0;
  int   last_tog = 0;

  // Expected-stream model helpers
  task automatic push(input int kind, input logic data, input logic [4:0] slot,
                      input logic [1:0] pre, input int at);
    exp_t e;
    e.kind = kind; e.data = data; e.slot = slot; e.pre = pre;
    e.lock = m_locked; e.at = at;
    sb.push_back(e);
  endtask

  task automatic iv(input int n);
    repeat (n) @(negedge clk);
    i_spdif  = ~i_spdif;
    last_tog = cyc;
  endtask

  task automatic model_err(input int at);
    m_good = 0; m_locked = 1'b0; m_expx = 1'b0;
    push(K_ERR, 1'b0, 5'd0, 2'd0, at);
  endtask

  task automatic send_lead(input int new_u = 0);
    if (new_u != 0) begin
      repeat (4) @(negedge clk);
      i_ui  = CNT_W'(new_u);
      cur_u = new_u;
      iv(3 * cur_u - 4);
    end else begin
      iv(3 * cur_u);
    end
    if (m_expx) begin
      if (m_good < LOCK_PRE) m_good++;
      if (m_good == LOCK_PRE) m_locked = 1'b1;
    end
    m_expx = 1'b0;
  endtask

  task automatic send_pre_rest(input logic [1:0] p);
    case (p)
      2'd0:    begin iv(cur_u);     iv(cur_u); iv(3 * cur_u); end
      2'd1:    begin iv(3 * cur_u); iv(cur_u); iv(cur_u);     end
      default: begin iv(2 * cur_u); iv(cur_u); iv(2 * cur_u); end
    endcase
    push(K_PRE, 1'b0, 5'd4, p, last_tog + 4);
  endtask

  task automatic send_bits(input logic [27:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (bits[i]) begin iv(cur_u); iv(cur_u); end
      else iv(2 * cur_u);
      push(K_BIT, bits[i], 5'(4 + i), 2'd0, last_tog + 4);
    end
    if (n == 28) m_expx = 1'b1;
  endtask

  task automatic send_sub(input logic [1:0] p, input logic [27:0] bits);
    send_lead();
    send_pre_rest(p);
    send_bits(bits, 28);
  endtask

  task automatic expect_timeout();
    int n_to;
    n_to = (7 * cur_u + 1) / 2;
    model_err(last_tog + 3 + n_to + 2);
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  int   mon_kind, mon_nstb;
  bit   mon_ok;
  exp_t mon_e;
  always @(negedge clk) begin
    if (i_rst_n && (o_data_valid || o_pre_valid || o_err)) begin
      n_checks++;
      mon_nstb = int'(o_data_valid) + int'(o_pre_valid) + int'(o_err);
      mon_kind = o_err ? K_ERR : (o_pre_valid ? K_PRE : K_BIT);
      if (sb.size() == 0) begin
        $display("FAIL unexpected_strobe dv=%b pv=%b err=%b at cyc %0d, expected none",
                 o_data_valid, o_pre_valid, o_err, cyc);
      end else begin
        mon_e  = sb.pop_front();
        mon_ok = (mon_nstb == 1) && (mon_kind == mon_e.kind) &&
                 (o_locked === mon_e.lock) && (cyc == mon_e.at);
        if (mon_e.kind == K_PRE)
          mon_ok = mon_ok && (o_preamble === mon_e.pre) && (o_slot === 5'd4);
        if (mon_e.kind == K_BIT)
          mon_ok = mon_ok && (o_decoded_data === mon_e.data) && (o_slot === mon_e.slot);
        if (mon_ok) n_pass++;
        else
          $display("FAIL strobe kind=%0d/%0d n=%0d data=%b/%b slot=%0d/%0d pre=%0d/%0d lock=%b/%b cyc=%0d/%0d (got/exp)",
                   mon_kind, mon_e.kind, mon_nstb, o_decoded_data, mon_e.data, o_slot,
                   mon_e.slot, o_preamble, mon_e.pre, o_locked, mon_e.lock, cyc, mon_e.at);
      end
    end
  end

  task automatic test_reset();
    logic [11:0] outs;
    repeat (3) @(negedge clk);
    outs = {o_decoded_data, o_data_valid, o_slot, o_preamble, o_pre_valid, o_locked, o_err};
    n_checks++;
    if (outs !== 12'd0) $display("FAIL reset_outputs got=%h expected 0", outs);
    else n_pass++;
    i_rst_n = 1'b1;
    repeat (20) @(negedge clk);
    outs = {o_decoded_data, o_data_valid, o_slot, o_preamble, o_pre_valid, o_locked, o_err};
    n_checks++;
    if (outs !== 12'd0) $display("FAIL ui_zero_idle got=%h expected 0", outs);
    else n_pass++;
  endtask

  task automatic test_basic();
    iv(0);
    repeat (3) @(negedge clk);
    i_ui  = CNT_W'(4);
    cur_u = 4;
    iv(5);
    send_sub(2'd0, 28'h5555555);
    send_sub(2'd1, 28'h0F0F0F3);
  endtask

  task automatic test_w();
    send_sub(2'd2, 28'h0000000);
  endtask

  task automatic test_lock();
    send_sub(2'd0, 28'h9A5C3E1);
    n_checks++;
    if (o_locked !== 1'b1) $display("FAIL lock_after_clean got=%b expected 1", o_locked);
    else n_pass++;
    send_lead();
    send_pre_rest(2'd1);
    send_bits(28'h0000016, 5);
    iv(cur_u);
    iv(2 * cur_u);
    model_err(last_tog + 4);
    iv(cur_u);
    iv(2 * cur_u);
    iv(cur_u);
    n_checks++;
    if (o_locked !== 1'b0) $display("FAIL lock_drop got=%b expected 0", o_locked);
    else n_pass++;
    send_sub(2'd2, 28'h3C3C3C3);
  endtask

  task automatic test_timeout();
    expect_timeout();
    repeat (60) @(negedge clk);
    iv(1);
    iv(cur_u);
    send_sub(2'd0, 28'h1234567);
    send_sub(2'd1, 28'h7654321);
    send_sub(2'd2, 28'hFFFFFFF);
    n_checks++;
    if (o_locked !== 1'b1) $display("FAIL relock got=%b expected 1", o_locked);
    else n_pass++;
  endtask

  task automatic test_glitch();
    send_lead();
    send_pre_rest(2'd2);
    send_bits(28'h000000B, 4);
    iv(3);
    iv(1);
    model_err(last_tog + 4);
    iv(cur_u);
    send_sub(2'd0, 28'hAAAAAAA);
  endtask

  task automatic test_mode();
    send_sub(2'd1, 28'h5A5A5A5);
    send_sub(2'd2, 28'hC0FFEE1);
    send_lead(2);
    send_pre_rest(2'd0);
    send_bits(28'h0000000, 28);
    n_checks++;
    if (o_locked !== 1'b1) $display("FAIL lock_after_mode got=%b expected 1", o_locked);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [11:0] outs;
    send_lead();
    send_pre_rest(2'd1);
    send_bits(28'h0000025, 6);
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL missing_strobes got=%0d pending expected 0", sb.size());
    else n_pass++;
    #2;
    i_rst_n = 1'b0;
    i_ui    = '0;
    cur_u   = 0;
    sb.delete();
    m_good = 0; m_locked = 1'b0; m_expx = 1'b0;
    #1;
    outs = {o_decoded_data, o_data_valid, o_slot, o_preamble, o_pre_valid, o_locked, o_err};
    n_checks++;
    if (outs !== 12'd0) $display("FAIL async_reset got=%h expected 0", outs);
    else n_pass++;
    repeat (5) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (o_locked !== 1'b0) $display("FAIL post_reset_lock got=%b expected 0", o_locked);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w();
    test_lock();
    test_timeout();
    test_glitch();
    test_mode();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
